// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
package ps2_mouse_packet_decoder_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    // Header byte bit positions
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    localparam int PKT_LEN = 3;

endpackage

// File: rtl/ps2_mouse_packet_decoder_axis.sv
// One cursor axis: saturating position register moved by a signed 9-bit delta.
module ps2_axis_accumulator #(
    parameter int WIDTH = 10,
    parameter int INIT  = 320
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [8:0]       delta,
    input  logic             invert,
    input  logic             ovf,
    input  logic             update,
    input  logic [WIDTH-1:0] max_pos,
    output logic [WIDTH-1:0] pos
);
    localparam int SW = WIDTH + 2;

    logic signed [SW-1:0] delta_ext_s;
    logic signed [SW-1:0] sum_s;
    logic [WIDTH-1:0]     next_s;
    logic [WIDTH-1:0]     pos_r;

    // Signed sum with two guard bits, then clamp to [0, max_pos]
    always_comb begin
        delta_ext_s = {{(SW-9){delta[8]}}, delta};
        if (invert) begin
            sum_s = $signed({2'b00, pos_r}) - delta_ext_s;
        end else begin
            sum_s = $signed({2'b00, pos_r}) + delta_ext_s;
        end
        if (sum_s[SW-1]) begin
            next_s = {WIDTH{1'b0}};
        end else if (sum_s > $signed({2'b00, max_pos})) begin
            next_s = max_pos;
        end else begin
            next_s = sum_s[WIDTH-1:0];
        end
    end

    // Position register; an overflowed axis keeps its position
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_r <= WIDTH'(INIT);
        end else if (update && !ovf) begin
            pos_r <= next_s;
        end else begin
            pos_r <= pos_r;
        end
    end

    assign pos = pos_r;

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Aligns PS/2 bytes into 3-byte mouse packets, decodes them and tracks a clamped cursor.
module ps2_mouse_packet_decoder
    import ps2_mouse_packet_decoder_pkg::*;
#(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_byte_valid,
    input  logic [7:0]                  io_byte_bits,
    output logic                        io_pkt_valid,
    output logic                        io_btn_left,
    output logic                        io_btn_right,
    output logic                        io_btn_middle,
    output logic [8:0]                  io_dx,
    output logic [8:0]                  io_dy,
    output logic                        io_x_ovf,
    output logic                        io_y_ovf,
    output logic [$clog2(SCREEN_W)-1:0] io_cursor_x,
    output logic [$clog2(SCREEN_H)-1:0] io_cursor_y,
    output logic                        io_sync_err
);
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_r;
    logic [TW-1:0] tmo_cnt_r;
    logic [7:0]    pkt_r [PKT_LEN-1];

    logic       pkt_done_s;
    logic       tmo_hit_s;
    logic [8:0] dx_s;
    logic [8:0] dy_s;

    // The third byte is used straight off the bus so the cursor moves with io_pkt_valid
    assign pkt_done_s = (state_r == WAIT_B2) && io_byte_valid && pkt_r[0][SYNC];
    assign tmo_hit_s  = (state_r != WAIT_B0) && !io_byte_valid
                        && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    assign dx_s = {pkt_r[0][XSIGN], pkt_r[1]};
    assign dy_s = {pkt_r[0][YSIGN], io_byte_bits};

    // Packet alignment FSM, timeout counter and registered decode outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= WAIT_B0;
            tmo_cnt_r     <= {TW{1'b0}};
            pkt_r[0]      <= 8'h00;
            pkt_r[1]      <= 8'h00;
            io_pkt_valid  <= 1'b0;
            io_sync_err   <= 1'b0;
            io_btn_left   <= 1'b0;
            io_btn_right  <= 1'b0;
            io_btn_middle <= 1'b0;
            io_dx         <= 9'h000;
            io_dy         <= 9'h000;
            io_x_ovf      <= 1'b0;
            io_y_ovf      <= 1'b0;
        end else begin
            io_pkt_valid <= 1'b0;
            io_sync_err  <= 1'b0;
            case (state_r)
                WAIT_B0: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    if (io_byte_valid) begin
                        if (io_byte_bits[SYNC]) begin
                            pkt_r[0] <= io_byte_bits;
                            state_r  <= WAIT_B1;
                        end else begin
                            io_sync_err <= 1'b1;
                        end
                    end else begin
                        state_r <= WAIT_B0;
                    end
                end
                WAIT_B1: begin
                    if (io_byte_valid) begin
                        pkt_r[1]  <= io_byte_bits;
                        tmo_cnt_r <= {TW{1'b0}};
                        state_r   <= WAIT_B2;
                    end else if (tmo_hit_s) begin
                        tmo_cnt_r   <= {TW{1'b0}};
                        io_sync_err <= 1'b1;
                        state_r     <= WAIT_B0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                WAIT_B2: begin
                    if (io_byte_valid) begin
                        tmo_cnt_r <= {TW{1'b0}};
                        state_r   <= WAIT_B0;
                        // A corrupted stored header is reported rather than decoded
                        if (pkt_done_s) begin
                            io_pkt_valid  <= 1'b1;
                            io_btn_left   <= pkt_r[0][BTN_L];
                            io_btn_right  <= pkt_r[0][BTN_R];
                            io_btn_middle <= pkt_r[0][BTN_M];
                            io_dx         <= dx_s;
                            io_dy         <= dy_s;
                            io_x_ovf      <= pkt_r[0][XOVF];
                            io_y_ovf      <= pkt_r[0][YOVF];
                        end else begin
                            io_sync_err <= 1'b1;
                        end
                    end else if (tmo_hit_s) begin
                        tmo_cnt_r   <= {TW{1'b0}};
                        io_sync_err <= 1'b1;
                        state_r     <= WAIT_B0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                default: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    state_r   <= WAIT_B0;
                end
            endcase
        end
    end

    ps2_axis_accumulator #(
        .WIDTH (XW),
        .INIT  (SCREEN_W / 2)
    ) u_axis_x (
        .clock   (clock),
        .reset   (reset),
        .delta   (dx_s),
        .invert  (1'b0),
        .ovf     (pkt_r[0][XOVF]),
        .update  (pkt_done_s),
        .max_pos (XW'(SCREEN_W - 1)),
        .pos     (io_cursor_x)
    );

    // Screen Y grows downward, so a positive mouse dy moves the cursor up
    ps2_axis_accumulator #(
        .WIDTH (YW),
        .INIT  (SCREEN_H / 2)
    ) u_axis_y (
        .clock   (clock),
        .reset   (reset),
        .delta   (dy_s),
        .invert  (1'b1),
        .ovf     (pkt_r[0][YOVF]),
        .update  (pkt_done_s),
        .max_pos (YW'(SCREEN_H - 1)),
        .pos     (io_cursor_y)
    );

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Scoreboard bench for the PS/2 mouse packet decoder with a byte-queue reference model.
module tb_ps2_mouse_packet_decoder;
    localparam int T = 40;
    localparam int W = 640;
    localparam int H = 480;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_byte_valid;
    logic [7:0] io_byte_bits;
    logic       io_pkt_valid;
    logic       io_btn_left, io_btn_right, io_btn_middle;
    logic [8:0] io_dx, io_dy;
    logic       io_x_ovf, io_y_ovf;
    logic [9:0] io_cursor_x;
    logic [8:0] io_cursor_y;
    logic       io_sync_err;

    ps2_mouse_packet_decoder #(
        .SCREEN_W       (W),
        .SCREEN_H       (H),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_byte_valid (io_byte_valid),
        .io_byte_bits  (io_byte_bits),
        .io_pkt_valid  (io_pkt_valid),
        .io_btn_left   (io_btn_left),
        .io_btn_right  (io_btn_right),
        .io_btn_middle (io_btn_middle),
        .io_dx         (io_dx),
        .io_dy         (io_dy),
        .io_x_ovf      (io_x_ovf),
        .io_y_ovf      (io_y_ovf),
        .io_cursor_x   (io_cursor_x),
        .io_cursor_y   (io_cursor_y),
        .io_sync_err   (io_sync_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_pkt;
        bit         l, r, m, xo, yo;
        logic [8:0] dx, dy;
        int         cx, cy;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] mq[$];
    int         mx = W / 2;
    int         my = H / 2;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic push_sync();
        ev_t e;
        e = '{default: 0};
        e.is_pkt = 1'b0;
        e.cx = mx;
        e.cy = my;
        exp_q.push_back(e);
    endtask

    // Reference: collect bytes into a packet list; decode with integer arithmetic
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        int  ddx, ddy;
        if (mq.size() == 0) begin
            if (b[3]) mq.push_back(b);
            else push_sync();
        end else begin
            mq.push_back(b);
            if (mq.size() == 3) begin
                e.is_pkt = 1'b1;
                e.l  = mq[0][0];
                e.r  = mq[0][1];
                e.m  = mq[0][2];
                e.xo = mq[0][6];
                e.yo = mq[0][7];
                e.dx = {mq[0][4], mq[1]};
                e.dy = {mq[0][5], mq[2]};
                ddx = mq[0][4] ? int'(mq[1]) - 256 : int'(mq[1]);
                ddy = mq[0][5] ? int'(mq[2]) - 256 : int'(mq[2]);
                if (!e.xo) mx = clampi(mx + ddx, W - 1);
                if (!e.yo) my = clampi(my - ddy, H - 1);
                e.cx = mx;
                e.cy = my;
                exp_q.push_back(e);
                mq.delete();
            end
        end
    endtask

    // Drive one byte for one cycle, then 'gap' idle cycles
    task automatic send(input logic [7:0] b, input int gap);
        io_byte_valid = 1'b1;
        io_byte_bits  = b;
        model_byte(b);
        @(negedge clock);
        io_byte_valid = 1'b0;
        io_byte_bits  = 8'($urandom);
        if (mq.size() != 0 && gap >= T) begin
            push_sync();
            mq.delete();
        end
        repeat (gap) @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * T) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        io_byte_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_pkt_valid", io_pkt_valid, 0);
        chk("rst_sync_err", io_sync_err, 0);
        chk("rst_buttons", {io_btn_left, io_btn_right, io_btn_middle}, 0);
        chk("rst_dx", io_dx, 0);
        chk("rst_dy", io_dy, 0);
        chk("rst_ovf", {io_x_ovf, io_y_ovf}, 0);
        chk("rst_cursor_x", io_cursor_x, W / 2);
        chk("rst_cursor_y", io_cursor_y, H / 2);
        reset = 1'b0;
        mq.delete();
        mx = W / 2;
        my = H / 2;
        @(negedge clock);
    endtask

    // Monitor: every pulse must match the oldest expected event
    always @(negedge clock) begin
        if (!reset && (io_pkt_valid || io_sync_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event pkt=%0d sync=%0d required=none",
                         io_pkt_valid, io_sync_err);
            end else begin
                automatic ev_t e = exp_q.pop_front();
                chk("ev_pkt_valid", io_pkt_valid, e.is_pkt);
                chk("ev_sync_err", io_sync_err, !e.is_pkt);
                chk("cursor_x", io_cursor_x, e.cx);
                chk("cursor_y", io_cursor_y, e.cy);
                if (e.is_pkt) begin
                    chk("btn_lrm", {io_btn_left, io_btn_right, io_btn_middle},
                        {e.l, e.r, e.m});
                    chk("dx", io_dx, e.dx);
                    chk("dy", io_dy, e.dy);
                    chk("ovf_xy", {io_x_ovf, io_y_ovf}, {e.xo, e.yo});
                end
            end
        end
    end

    initial begin
        io_byte_valid = 1'b0;
        io_byte_bits  = 8'h00;
        reset = 1'b1;
        @(negedge clock);
        do_reset();

        send(8'h09, 0); send(8'h05, 0); send(8'h03, 2);
        drain(); do_reset();

        send(8'h38, 1); send(8'hFB, 0); send(8'hFE, 2);
        drain(); do_reset();

        for (int k = 0; k < 4; k++) begin
            send(8'h08, 0); send(8'h7F, 0); send(8'h00, 1);
        end
        drain();
        chk("clamp_x_hold", io_cursor_x, W - 1);
        chk("clamp_y_hold", io_cursor_y, H / 2);
        do_reset();

        send(8'h05, 2);
        send(8'h09, 0); send(8'h01, 0); send(8'h00, 2);
        drain(); do_reset();

        send(8'h08, 0); send(8'h10, T + 3);
        send(8'h09, 0); send(8'h02, 0); send(8'h00, 2);
        send(8'h08, T - 1); send(8'h10, T - 1); send(8'h00, 2);
        send(8'h08, T); send(8'h09, 0); send(8'h03, 0); send(8'h04, 2);
        drain(); do_reset();

        send(8'h48, 0); send(8'h10, 0); send(8'h10, 2);
        drain();
        send(8'h09, 0); send(8'h22, 1);
        do_reset();
        repeat (3) @(negedge clock);

        for (int i = 0; i < 400; i++) begin
            automatic logic [7:0] b = 8'($urandom);
            automatic int r = int'($urandom_range(0, 19));
            automatic int g;
            if (mq.size() == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
            if (r < 16)       g = int'($urandom_range(0, 3));
            else if (r == 16) g = T - 1;
            else if (r == 17) g = T;
            else if (r == 18) g = T + 2;
            else              g = 0;
            send(b, g);
        end
        send(8'h08, T + 1);
        drain();
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
